// File: rtl/divisor_secuencial_pkg.sv
// divisor_secuencial_pkg: shared state encoding and constants for the sequential divider
package divisor_secuencial_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX, ST_DONE} state_t;
   localparam int N_DEF = 32;
   localparam logic [63:0] DIV0_Q = '1;
   function automatic int div_latency(input int n);
      return n + 1;
   endfunction
   localparam int DIV_LATENCY = div_latency(N_DEF);
endpackage

// File: rtl/divisor_paso.sv
// divisor_paso: one combinational restoring-division step
module divisor_paso #(
   parameter int N = 32
) (
   input  logic [N:0]   i_rem,
   input  logic [N-1:0] i_div,
   input  logic         i_bit,
   output logic [N:0]   o_rem,
   output logic         o_q
);
   logic [N+1:0] w_sh, w_diff;
   assign w_sh   = {i_rem, i_bit};
   // partial remainder stays below the divisor, so the extra MSB is a clean borrow flag
   assign w_diff = w_sh - {2'b00, i_div};
   assign o_q    = ~w_diff[N+1];
   assign o_rem  = o_q ? w_diff[N:0] : w_sh[N:0];
endmodule

// File: rtl/divisor_secuencial.sv
// divisor_secuencial: iterative restoring divider, signed/unsigned, RISC-V divide-by-zero semantics
import divisor_secuencial_pkg::*;
module divisor_secuencial #(
   parameter int N = N_DEF
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic         signed_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [N-1:0] cociente_o,
   output logic [N-1:0] residuo_o,
   output logic         div_cero_o
);
   localparam int CW = $clog2(N);
   state_t         r_state, w_next;
   logic [CW-1:0]  r_cnt;
   logic [N:0]     r_rem, w_rem;
   logic [N-1:0]   r_dvd, r_div, r_coc, r_res, w_ma, w_mb;
   logic           r_sq, r_sr, r_dz, w_qbit, w_sa, w_sb;
   assign w_sa = signed_i & a_i[N-1];
   assign w_sb = signed_i & b_i[N-1];
   assign w_ma = w_sa ? -a_i : a_i;
   assign w_mb = w_sb ? -b_i : b_i;
   divisor_paso #(.N(N)) u_paso (
      .i_rem (r_rem),
      .i_div (r_div),
      .i_bit (r_dvd[N-1]),
      .o_rem (w_rem),
      .o_q   (w_qbit)
   );
   always_ff @(posedge clk_i) r_state <= rst_i ? ST_IDLE : w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: w_next = !start_i ? ST_IDLE : (b_i == '0) ? ST_DONE : ST_CALC;
         ST_CALC: w_next = (r_cnt == '0) ? ST_FIX : ST_CALC;
         ST_FIX:  w_next = ST_DONE;
         default: w_next = ST_IDLE;
      endcase
   end
   // dividend register shifts out its MSB and collects quotient bits at the LSB
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt <= '0;
         r_rem <= '0;
         r_dvd <= '0;
         r_div <= '0;
         r_sq  <= 1'b0;
         r_sr  <= 1'b0;
         r_coc <= '0;
         r_res <= '0;
         r_dz  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (start_i) begin
               if (b_i == '0) begin
                  r_coc <= DIV0_Q[N-1:0];
                  r_res <= a_i;
                  r_dz  <= 1'b1;
               end else begin
                  r_dvd <= w_ma;
                  r_div <= w_mb;
                  r_sq  <= w_sa ^ w_sb;
                  r_sr  <= w_sa;
                  r_rem <= '0;
                  r_cnt <= CW'(N - 1);
               end
            end
            ST_CALC: begin
               r_rem <= w_rem;
               r_dvd <= {r_dvd[N-2:0], w_qbit};
               r_cnt <= (r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
            end
            ST_FIX: begin
               r_coc <= r_sq ? -r_dvd : r_dvd;
               r_res <= r_sr ? -r_rem[N-1:0] : r_rem[N-1:0];
               r_dz  <= 1'b0;
            end
            default: ;
         endcase
      end
   end
   assign busy_o     = (r_state == ST_CALC) || (r_state == ST_FIX);
   assign done_o     = (r_state == ST_DONE);
   assign cociente_o = r_coc;
   assign residuo_o  = r_res;
   assign div_cero_o = r_dz;
endmodule

// File: tb/tb_divisor_secuencial.sv
// tb_divisor_secuencial: scoreboard bench for N=32 directed/random cases and an N=4 exhaustive sweep
module tb_divisor_secuencial;
   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } exp_t;
   logic clk = 1'b0, rst = 1'b1;
   logic st32 = 1'b0, sg32 = 1'b0, busy32, done32, dz32;
   logic [31:0] a32 = '0, b32 = '0, coc32, res32;
   logic st4 = 1'b0, sg4 = 1'b0, busy4, done4, dz4;
   logic [3:0] a4 = '0, b4 = '0, coc4, res4;
   int n_chk = 0, n_err = 0;
   exp_t sb32[$], sb4[$];
   always #5 clk = ~clk;
   divisor_secuencial #(.N(32)) dut32 (
      .clk_i(clk), .rst_i(rst), .start_i(st32), .signed_i(sg32), .a_i(a32), .b_i(b32),
      .busy_o(busy32), .done_o(done32), .cociente_o(coc32), .residuo_o(res32), .div_cero_o(dz32)
   );
   divisor_secuencial #(.N(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .start_i(st4), .signed_i(sg4), .a_i(a4), .b_i(b4),
      .busy_o(busy4), .done_o(done4), .cociente_o(coc4), .residuo_o(res4), .div_cero_o(dz4)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic exp_t model(input int n, input bit s, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [63:0] m, ua, ub, ma, mb, q, r;
      bit sa, sb;
      m  = (64'd1 << n) - 64'd1;
      ua = {32'd0, a} & m;
      ub = {32'd0, b} & m;
      if (ub == 64'd0) begin
         e.q = m[31:0]; e.r = ua[31:0]; e.dz = 1'b1;
         return e;
      end
      sa = s && ua[n-1];
      sb = s && ub[n-1];
      ma = sa ? (-ua) & m : ua;
      mb = sb ? (-ub) & m : ub;
      q  = ma / mb;
      r  = ma % mb;
      if (sa ^ sb) q = (-q) & m;
      if (sa) r = (-r) & m;
      e.q = q[31:0]; e.r = r[31:0]; e.dz = 1'b0;
      return e;
   endfunction
   always @(negedge clk) if (done32) begin
      if (sb32.size() == 0) chk("done32_unexpected", 1, 0);
      else begin
         exp_t e;
         e = sb32.pop_front();
         chk("q32", coc32, e.q);
         chk("r32", res32, e.r);
         chk("dz32", dz32, e.dz);
      end
   end
   always @(negedge clk) if (done4) begin
      if (sb4.size() == 0) chk("done4_unexpected", 1, 0);
      else begin
         exp_t e;
         e = sb4.pop_front();
         chk("q4", coc4, e.q);
         chk("r4", res4, e.r);
         chk("dz4", dz4, e.dz);
      end
   end
   task automatic run32(input bit s, input logic [31:0] a, input logic [31:0] b, input int inj);
      exp_t e;
      int lat, nb;
      e = model(32, s, a, b);
      @(negedge clk);
      st32 = 1'b1; sg32 = s; a32 = a; b32 = b;
      sb32.push_back(e);
      @(negedge clk);
      st32 = 1'b0;
      lat = 0; nb = 0;
      while (!done32 && lat < 200) begin
         nb += int'(busy32);
         st32 = (inj != 0 && lat == inj);
         if (st32) begin a32 = 32'd9; b32 = 32'd4; end
         @(negedge clk);
         lat++;
      end
      st32 = 1'b0;
      chk("lat32", lat, (b == 0) ? 0 : 33);
      chk("busy32_cycles", nb, (b == 0) ? 0 : 33);
      @(negedge clk);
      chk("done32_pulse", done32, 0);
      chk("hold_q32", coc32, e.q);
   endtask
   task automatic run4(input bit s, input logic [3:0] a, input logic [3:0] b);
      int lat;
      @(negedge clk);
      st4 = 1'b1; sg4 = s; a4 = a; b4 = b;
      sb4.push_back(model(4, s, {28'd0, a}, {28'd0, b}));
      @(negedge clk);
      st4 = 1'b0;
      lat = 0;
      while (!done4 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk("lat4", lat, (b == 0) ? 0 : 5);
      @(negedge clk);
      chk("done4_pulse", done4, 0);
   endtask
   initial begin
      int nd;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy32, 0);
      chk("rst_done", done32, 0);
      chk("rst_q", coc32, 0);
      chk("rst_r", res32, 0);
      chk("rst_dz", dz32, 0);
      rst = 1'b0;
      run32(0, 32'd100, 32'd7, 0);
      run32(1, 32'hFFFF_FFF9, 32'd2, 0);
      run32(1, 32'd7, 32'hFFFF_FFFE, 0);
      run32(1, 32'd5, 32'd0, 0);
      run32(0, 32'd5, 32'd0, 0);
      run32(1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run32(0, 32'hFFFF_FFFF, 32'd1, 0);
      run32(0, 32'd100, 32'd7, 5);
      for (int i = 0; i < 8; i++)
         run32(1'($urandom_range(0, 1)), $urandom, $urandom >> $urandom_range(0, 31), 0);
      @(negedge clk);
      st32 = 1'b1; sg32 = 1'b0; a32 = 32'd100; b32 = 32'd7;
      @(negedge clk);
      st32 = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", busy32, 0);
      chk("midrst_done", done32, 0);
      chk("midrst_q", coc32, 0);
      chk("midrst_r", res32, 0);
      chk("midrst_dz", dz32, 0);
      nd = 0;
      repeat (40) begin
         @(negedge clk);
         nd += int'(done32);
      end
      chk("midrst_no_done", nd, 0);
      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
               run4(1'(s), 4'(a), 4'(b));
      chk("sb32_empty", sb32.size(), 0);
      chk("sb4_empty", sb4.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
